// File: rtl/cmip_sync_fifo_ctrl_pkg.sv
// Shared helpers for the synchronous FIFO controller: prefetch sizing and
// wrap-bit aware pointer arithmetic.
package cmip_sync_fifo_ctrl_pkg;

  // The prefetch buffer covers every word in flight plus the one being shown.
  function automatic int pf_depth(input int read_latency);
    return read_latency + 1;
  endfunction

  // Difference of two wrap-bit pointers, reduced modulo 2^ptr_w.
  function automatic logic [31:0] ptr_diff(input logic [31:0] wptr,
                                           input logic [31:0] rptr,
                                           input int          ptr_w);
    logic [31:0] mask;
    mask = (ptr_w >= 32) ? '1 : ((32'd1 << ptr_w) - 32'd1);
    return (wptr - rptr) & mask;
  endfunction

  // Index increment for ring buffers whose depth need not be a power of two.
  function automatic logic [31:0] wrap_inc(input logic [31:0] idx, input int depth);
    return (idx == 32'(depth - 1)) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/cmip_fifo_prefetch_buf.sv
// Small register FIFO holding words returned from memory; head is always visible.
module cmip_fifo_prefetch_buf
  import cmip_sync_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH     = 5,
  parameter int DATA_WDTH = 32,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_push,
  input  logic [DATA_WDTH-1:0] i_wdata,
  input  logic                 i_pop,
  output logic [DATA_WDTH-1:0] o_head,
  output logic [CNT_W-1:0]     o_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WDTH-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]     r_wr_idx;
  logic [IDX_W-1:0]     r_rd_idx;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_pop;

  assign w_pop = i_pop & (r_cnt != '0);

  // NOTE: storage has no reset; only the indices and count need a known state.
  // NOTE: non-blocking assignments make every register sample pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_idx] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push) r_wr_idx <= IDX_W'(wrap_inc(32'(r_wr_idx), DEPTH));
      if (w_pop)  r_rd_idx <= IDX_W'(wrap_inc(32'(r_rd_idx), DEPTH));
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign o_head = r_mem[r_rd_idx];
  assign o_cnt  = r_cnt;

  // The credit scheme upstream guarantees a free slot for every capture.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && (r_cnt == CNT_W'(DEPTH))));

endmodule

// File: rtl/cmip_sync_fifo_ctrl.sv
// FIFO controller for a registered simple-dual-port memory, presenting a
// show-ahead valid/ready stream with the read latency hidden by prefetch.
module cmip_sync_fifo_ctrl
  import cmip_sync_fifo_ctrl_pkg::*;
#(
  parameter int DPTH         = 1024,
  parameter int DATA_WDTH    = 32,
  parameter int ADDR_WDTH    = $clog2(DPTH),
  parameter int READ_LATENCY = 4,
  parameter int AFULL_TH     = DPTH - 4,
  parameter int AEMPTY_TH    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wr_vld,
  input  logic [DATA_WDTH-1:0] i_wr_data,
  output logic                 o_wr_rdy,
  output logic                 o_rd_vld,
  output logic [DATA_WDTH-1:0] o_rd_data,
  input  logic                 i_rd_rdy,
  output logic                 o_mem_wr,
  output logic [ADDR_WDTH-1:0] o_mem_waddr,
  output logic [DATA_WDTH-1:0] o_mem_wdata,
  output logic                 o_mem_rd,
  output logic [ADDR_WDTH-1:0] o_mem_raddr,
  input  logic [DATA_WDTH-1:0] i_mem_rdata,
  output logic [ADDR_WDTH+1:0] o_level,
  output logic                 o_afull,
  output logic                 o_aempty
);

  localparam int PF_DPTH = pf_depth(READ_LATENCY);
  localparam int PW      = ADDR_WDTH + 1;
  localparam int LW      = ADDR_WDTH + 2;
  localparam int PCW     = $clog2(PF_DPTH + 1);
  localparam int IW      = $clog2(READ_LATENCY + 1);
  localparam int CW      = $clog2(PF_DPTH + 2) + 1;

  logic [PW-1:0]           r_wptr;
  logic [PW-1:0]           r_rptr;
  logic [READ_LATENCY-1:0] r_vld_sr;
  logic                    r_afull;
  logic                    r_aempty;

  logic [PW-1:0]  w_mem_cnt;
  logic [PCW-1:0] w_pf_cnt;
  logic [IW-1:0]  w_infl_cnt;
  logic [CW-1:0]  w_credit;
  logic [LW-1:0]  w_level;
  logic           w_push;
  logic           w_pop;
  logic           w_issue;
  logic           w_capture;

  assign w_mem_cnt  = PW'(ptr_diff(32'(r_wptr), 32'(r_rptr), PW));
  assign o_wr_rdy   = (w_mem_cnt != PW'(DPTH));
  assign w_push     = i_wr_vld & o_wr_rdy;
  assign w_pop      = o_rd_vld & i_rd_rdy;
  assign w_infl_cnt = IW'($countones(r_vld_sr));
  assign w_capture  = r_vld_sr[READ_LATENCY-1];

  // A same-cycle pop frees a slot, so reads keep streaming at one per cycle.
  assign w_credit = CW'(PF_DPTH) - CW'(w_infl_cnt) - CW'(w_pf_cnt) + CW'(w_pop);
  assign w_issue  = (w_mem_cnt != '0) & (w_credit != '0);

  assign o_mem_wr    = w_push;
  assign o_mem_waddr = r_wptr[ADDR_WDTH-1:0];
  assign o_mem_wdata = i_wr_data;
  assign o_mem_rd    = w_issue;
  assign o_mem_raddr = r_rptr[ADDR_WDTH-1:0];

  assign w_level  = LW'(w_mem_cnt) + LW'(w_infl_cnt) + LW'(w_pf_cnt);
  assign o_level  = w_level;
  assign o_afull  = r_afull;
  assign o_aempty = r_aempty;
  assign o_rd_vld = (w_pf_cnt != '0);

  // Clearing the valid shift register on reset drops any stale read returns.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_vld_sr <= '0;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      if (w_push)  r_wptr <= r_wptr + PW'(1);
      if (w_issue) r_rptr <= r_rptr + PW'(1);
      r_vld_sr <= (r_vld_sr << 1) | READ_LATENCY'(w_issue);
      r_afull  <= (int'(w_mem_cnt) >= AFULL_TH);
      r_aempty <= (int'(w_level) <= AEMPTY_TH);
    end
  end

  cmip_fifo_prefetch_buf #(
    .DEPTH     (PF_DPTH),
    .DATA_WDTH (DATA_WDTH),
    .CNT_W     (PCW)
  ) u_pf_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_capture),
    .i_wdata (i_mem_rdata),
    .i_pop   (w_pop),
    .o_head  (o_rd_data),
    .o_cnt   (w_pf_cnt)
  );

endmodule

// File: tb/tb_cmip_sync_fifo_ctrl.sv
// Scoreboard bench for cmip_sync_fifo_ctrl with a behavioural registered memory.
module tb_cmip_sync_fifo_ctrl;

  localparam int DPTH = 16;
  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int RL   = 4;
  localparam int LW   = AW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_vld = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_rdy = 1'b0;
  logic          o_wr_rdy, o_rd_vld, o_mem_wr, o_mem_rd, o_afull, o_aempty;
  logic [DW-1:0] o_rd_data, o_mem_wdata, mem_rdata;
  logic [AW-1:0] o_mem_waddr, o_mem_raddr;
  logic [LW-1:0] o_level;

  int n_checks = 0;
  int n_errors = 0;
  int model_level = 0;
  int n_popped = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_w;

  always #5 clk = ~clk;

  cmip_sync_fifo_ctrl #(
    .DPTH(DPTH), .DATA_WDTH(DW), .ADDR_WDTH(AW), .READ_LATENCY(RL),
    .AFULL_TH(DPTH - 4), .AEMPTY_TH(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_vld(wr_vld), .i_wr_data(wr_data), .o_wr_rdy(o_wr_rdy),
    .o_rd_vld(o_rd_vld), .o_rd_data(o_rd_data), .i_rd_rdy(rd_rdy),
    .o_mem_wr(o_mem_wr), .o_mem_waddr(o_mem_waddr), .o_mem_wdata(o_mem_wdata),
    .o_mem_rd(o_mem_rd), .o_mem_raddr(o_mem_raddr), .i_mem_rdata(mem_rdata),
    .o_level(o_level), .o_afull(o_afull), .o_aempty(o_aempty)
  );

  // Memory model: read sampled at an edge appears RL-1 edges later; not reset.
  logic [DW-1:0] mem [DPTH];
  logic [DW-1:0] rpipe [RL];
  always @(posedge clk) begin
    if (o_mem_wr) mem[o_mem_waddr] <= o_mem_wdata;
    rpipe[0] <= o_mem_rd ? mem[o_mem_raddr] : 32'hDEAD_BEEF;
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[RL-1];

  // Scoreboard and level model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_level = 0;
    end else begin
      n_checks++;
      if (o_level !== LW'(model_level)) begin
        n_errors++;
        $display("FAIL level_model: got %0d expected %0d at %0t", o_level, model_level, $time);
      end
      if (o_rd_vld && rd_rdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL sb_underflow: got %0h expected no word at %0t", o_rd_data, $time);
        end else begin
          exp_w = exp_q.pop_front();
          if (o_rd_data !== exp_w) begin
            n_errors++;
            $display("FAIL sb_data: got %0h expected %0h at %0t", o_rd_data, exp_w, $time);
          end
        end
        model_level--;
        n_popped++;
      end
      if (wr_vld && o_wr_rdy) begin
        exp_q.push_back(wr_data);
        model_level++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done = 0;
    wr_vld = 1'b0;
    rd_rdy = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (o_level == '0 && exp_q.size() == 0 && !o_rd_vld) done = 1;
    end
    rd_rdy = 1'b0;
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL drain_timeout: got level %0d queue %0d expected 0 0", o_level, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_vld = 1'b0; rd_rdy = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({o_wr_rdy, o_rd_vld, o_afull, o_aempty, o_mem_rd, o_mem_wr} !== 6'b100100) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 100100",
               {o_wr_rdy, o_rd_vld, o_afull, o_aempty, o_mem_rd, o_mem_wr});
    end
    n_checks++;
    if (o_level !== '0) begin
      n_errors++; $display("FAIL reset_level: got %0d expected 0", o_level);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (o_wr_rdy !== 1'b1 || o_rd_vld !== 1'b0 || o_aempty !== 1'b1) begin
      n_errors++;
      $display("FAIL release_flags: got rdy %b vld %b aempty %b expected 1 0 1", o_wr_rdy, o_rd_vld, o_aempty);
    end
  endtask

  task automatic test_single();
    int early = 0;
    rd_rdy = 1'b0;
    wr_vld = 1'b1; wr_data = 32'hA5;
    tick();
    wr_vld = 1'b0;
    n_checks++;
    if (o_mem_rd !== 1'b1) begin
      n_errors++; $display("FAIL single_issue: got mem_rd %b expected 1", o_mem_rd);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_rd_vld !== 1'b0) early++;
      if (i == 0) begin
        n_checks++;
        if (o_mem_rd !== 1'b0) begin
          n_errors++; $display("FAIL single_one_issue: got mem_rd %b expected 0", o_mem_rd);
        end
      end
    end
    n_checks++;
    if (early != 0) begin
      n_errors++; $display("FAIL single_early_vld: got %0d early cycles expected 0", early);
    end
    tick();
    n_checks++;
    if (o_rd_vld !== 1'b1 || o_rd_data !== 32'hA5 || o_level !== LW'(1)) begin
      n_errors++;
      $display("FAIL single_out: got vld %b data %0h level %0d expected 1 a5 1", o_rd_vld, o_rd_data, o_level);
    end
    drain();
  endtask

  task automatic test_stream();
    int seen = 0, gaps = 0, outs = 0, drops = 0;
    rd_rdy = 1'b1;
    for (int cyc = 0; cyc < 300 && outs < 100; cyc++) begin
      if (cyc < 100) begin
        wr_vld = 1'b1; wr_data = 32'(cyc);
        if (!o_wr_rdy) drops++;
      end else wr_vld = 1'b0;
      if (o_rd_vld) begin seen = 1; outs++; end
      else if (seen != 0) gaps++;
      tick();
    end
    wr_vld = 1'b0;
    n_checks++;
    if (drops != 0 || gaps != 0 || outs != 100) begin
      n_errors++;
      $display("FAIL stream: got drops %0d gaps %0d outs %0d expected 0 0 100", drops, gaps, outs);
    end
    drain();
  endtask

  task automatic test_fill();
    int drops = 0;
    rd_rdy = 1'b0;
    for (int i = 0; i < 21; i++) begin
      wr_vld = 1'b1; wr_data = 32'h100 + 32'(i);
      if (!o_wr_rdy) drops++;
      tick();
    end
    wr_vld = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (drops != 0 || o_level !== LW'(21) || o_wr_rdy !== 1'b0 || o_afull !== 1'b1) begin
      n_errors++;
      $display("FAIL fill_state: got drops %0d level %0d rdy %b afull %b expected 0 21 0 1",
               drops, o_level, o_wr_rdy, o_afull);
    end
    n_checks++;
    if (o_rd_vld !== 1'b1 || o_rd_data !== 32'h100) begin
      n_errors++; $display("FAIL fill_head: got vld %b data %0h expected 1 100", o_rd_vld, o_rd_data);
    end
    wr_vld = 1'b1; wr_data = 32'hBAD;
    tick();
    wr_vld = 1'b0;
    n_checks++;
    if (o_level !== LW'(21)) begin
      n_errors++; $display("FAIL fill_refuse: got level %0d expected 21", o_level);
    end
    rd_rdy = 1'b1;
    #1;
    n_checks++;
    if (o_mem_rd !== 1'b1) begin
      n_errors++; $display("FAIL fill_pop_issue: got mem_rd %b expected 1", o_mem_rd);
    end
    tick();
    rd_rdy = 1'b0;
    n_checks++;
    if (o_wr_rdy !== 1'b1 || o_level !== LW'(20)) begin
      n_errors++; $display("FAIL fill_reopen: got rdy %b level %0d expected 1 20", o_wr_rdy, o_level);
    end
    drain();
  endtask

  task automatic test_random();
    int max_level = 0;
    for (int i = 0; i < 10000; i++) begin
      wr_vld  = 1'($urandom_range(0, 1));
      wr_data = $urandom;
      rd_rdy  = 1'($urandom_range(0, 1));
      tick();
      if (int'(o_level) > max_level) max_level = int'(o_level);
    end
    n_checks++;
    if (max_level > DPTH + RL + 1) begin
      n_errors++; $display("FAIL random_bound: got max level %0d expected <= %0d", max_level, DPTH + RL + 1);
    end
    drain();
  endtask

  task automatic test_mid_reset();
    int stale = 0;
    bit got = 0;
    rd_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_vld = 1'b1; wr_data = 32'hC0 + 32'(i);
      tick();
    end
    wr_vld = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_wr_rdy, o_rd_vld, o_afull, o_aempty, o_mem_rd} !== 5'b10010 || o_level !== '0) begin
      n_errors++;
      $display("FAIL midrst_state: got %b level %0d expected 10010 0",
               {o_wr_rdy, o_rd_vld, o_afull, o_aempty, o_mem_rd}, o_level);
    end
    tick(); tick();
    rst_n = 1'b1;
    rd_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_rd_vld !== 1'b0) stale++;
    end
    n_checks++;
    if (stale != 0) begin
      n_errors++; $display("FAIL midrst_stale: got %0d valid cycles expected 0", stale);
    end
    rd_rdy = 1'b0;
    wr_vld = 1'b1; wr_data = 32'h5A;
    tick();
    wr_vld = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (o_rd_vld) got = 1;
    end
    n_checks++;
    if (!got || o_rd_data !== 32'h5A) begin
      n_errors++; $display("FAIL midrst_first: got vld %b data %0h expected 1 5a", got, o_rd_data);
    end
    drain();
  endtask

  task automatic test_wrap();
    int popped0;
    rd_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_vld = 1'b1; wr_data = 32'h200 + 32'(i);
      tick();
    end
    wr_vld = 1'b0;
    tick(); tick();
    n_checks++;
    if (o_aempty !== 1'b1 || o_level !== LW'(4)) begin
      n_errors++; $display("FAIL aempty_at4: got %b level %0d expected 1 4", o_aempty, o_level);
    end
    wr_vld = 1'b1; wr_data = 32'h204;
    tick();
    wr_vld = 1'b0;
    n_checks++;
    if (o_aempty !== 1'b1) begin
      n_errors++; $display("FAIL aempty_lag_rise: got %b expected 1", o_aempty);
    end
    tick();
    n_checks++;
    if (o_aempty !== 1'b0) begin
      n_errors++; $display("FAIL aempty_at5: got %b expected 0", o_aempty);
    end
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
    n_checks++;
    if (o_aempty !== 1'b0) begin
      n_errors++; $display("FAIL aempty_lag_fall: got %b expected 0", o_aempty);
    end
    tick();
    n_checks++;
    if (o_aempty !== 1'b1) begin
      n_errors++; $display("FAIL aempty_back4: got %b expected 1", o_aempty);
    end
    drain();
    popped0 = n_popped;
    rd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_vld = 1'b1; wr_data = 32'h1000 + 32'(i);
      tick();
    end
    wr_vld = 1'b0;
    drain();
    n_checks++;
    if (n_popped - popped0 != 40) begin
      n_errors++; $display("FAIL wrap_count: got %0d words expected 40", n_popped - popped0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_fill();
    test_random();
    test_mid_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
